alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
- Execute-stage sequencer that sits between instruction decode and the 16-bit ALU.
- Accepts one decoded instruction plus two operand values through a valid/ready handshake.
- Drives the ALU's op, operand, ltgt and eq inputs, waits one settle cycle, then captures the ALU's out and compres results.
- Emits either a register writeback or a branch redirect, so it is the issuing end of the ALU interface that the ALU itself only responds to.

Parameters:
DATA_W, 16, operand, result and PC width
OFF_W, 8, branch offset width (signed, two's complement)
NOP_OP, 4'h1, op code driven to the ALU when no instruction is in flight

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decoded instruction available
in_ready  output  1  controller can accept an instruction
in_instr  input  16  [15:12] op, [11] eq, [10:8] ltgt, [7:0] branch offset
in_src_a  input  DATA_W  first operand ($c1), sent to ALU res
in_src_b  input  DATA_W  second operand ($c2), sent to ALU register
in_pc  input  DATA_W  PC of the instruction
flush  input  1  synchronous abort of any in-flight instruction
alu_op  output  4  op code to ALU
alu_res  output  DATA_W  to ALU res
alu_register  output  DATA_W  to ALU register
alu_ltgt  output  3  to ALU ltgt
alu_eq  output  1  to ALU eq
alu_out  input  DATA_W  ALU result
alu_compres  input  1  ALU compare result
done  output  1  one-cycle completion pulse
wb_en  output  1  write wb_data (valid with done)
wb_data  output  DATA_W  writeback value
br_taken  output  1  branch redirect (valid with done)
br_target  output  DATA_W  redirect PC
illegal  output  1  one-cycle pulse for an unsupported op

Behaviour:
- Reset is asynchronous and active-high:
  - state goes to IDLE.
  - in_ready=1.
  - done, wb_en, br_taken and illegal are 0.
  - wb_data and br_target are 0.
  - alu_op=NOP_OP; alu_res, alu_register, alu_ltgt and alu_eq are 0.
  - Any in-flight instruction is discarded, with no done pulse.
- Legal ops and their handling:
  - 4'h0 is ADD/SUB: the ALU adds when eq=1 and subtracts when eq=0.
  - 4'h5 is EPAR and returns even parity in bit 0.
  - 4'h4 is BRANCH.
  - Every other op is illegal.
- FSM states are IDLE, EXEC and COMMIT. All outputs are registered.
- IDLE:
  - in_ready=1 and alu_op=NOP_OP.
  - On an edge with in_valid=1 and flush=0, latch instr, src_a, src_b and pc.
  - If the op is legal, go to EXEC.
  - If the op is illegal, pulse illegal for one cycle and stay in IDLE. done does not assert.
- EXEC (exactly 1 cycle):
  - in_ready=0.
  - alu_op, alu_res, alu_register, alu_ltgt and alu_eq are driven from the latched values and held stable for the whole cycle.
  - On the next edge, capture alu_out and alu_compres, then go to COMMIT.
- COMMIT (exactly 1 cycle):
  - done=1 and in_ready=0. ALU inputs stay held.
  - For ADD/SUB or EPAR: wb_en=1, wb_data=captured alu_out, br_taken=0.
  - For BRANCH: wb_en=0, br_taken=captured compres.
  - br_target = pc + 1 + sign_extend(offset), truncated modulo 2^DATA_W. It is always computed, even when the branch is not taken.
  - Next edge returns to IDLE, where done, wb_en and br_taken are 0.
- Latency and throughput: done is asserted in the second cycle after the accept edge. Throughput is one instruction per 3 cycles; no back-to-back acceptance.
- flush:
  - In EXEC or COMMIT, flush forces IDLE at the next edge with no done, wb_en or br_taken from that point.
  - If flush arrives during COMMIT, that cycle's done is still visible, since it is already registered.
  - In IDLE, flush blocks acceptance, even when in_valid=1.
- The controller passes ltgt and eq through unmodified and reports the ALU's compres as given; it does not second-guess compare semantics.
- in_src_* and in_pc are sampled only at the accept edge. Later changes have no effect.

Test Plan:
- Reset, then add: in_instr=16'h0800 (op 0, eq=1), src_a=16'h1234, src_b=16'h0011 -> alu_op=0 during EXEC; done=1, wb_en=1, wb_data=16'h1245 two cycles after accept.
- Subtract with wrap: in_instr=16'h0000, src_a=16'h0001, src_b=16'h0002 -> wb_data=16'hFFFF.
- Parity: in_instr=16'h5000, src_a=16'h0007 -> wb_data=16'h0001; src_a=16'h0003 -> wb_data=16'h0000.
- Branch taken, negative offset:
  - Stimulus: in_instr=16'h48FC (eq=1, ltgt=0, off=-4), src_a=src_b=16'h0042, pc=16'h0010.
  - Required: br_taken=1, br_target=16'h000D, wb_en=0.
  - Same instruction with src_b=16'h0043 -> br_taken=0.
- Illegal op and handshake:
  - Stimulus: in_instr=16'h7000.
  - Required: illegal pulses one cycle, done never rises, and in_ready is still 1 the next cycle.
  - With in_valid held high, in_ready drops for exactly 2 cycles per legal instruction.
- Abort paths:
  - flush asserted during EXEC -> no done, FSM returns to IDLE.
  - reset asserted mid-EXEC, asynchronously between edges -> all outputs go to their reset values immediately, and the next instruction executes normally.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Bundle between the execute-stage controller, the decode stage that feeds it,
// and the 16-bit ALU that it drives. The slave modport is the controller's view.
// The master modport is the environment's view (decode + ALU).
interface alu_exec_ctrl_if #(
  parameter int DATA_W = 16
) ();

  // Decode-side handshake and instruction payload
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [DATA_W-1:0] in_src_a;
  logic [DATA_W-1:0] in_src_b;
  logic [DATA_W-1:0] in_pc;
  logic              flush;

  // ALU operand side, driven by the controller
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] alu_register;
  logic [2:0]        alu_ltgt;
  logic              alu_eq;

  // ALU result side, returned to the controller
  logic [DATA_W-1:0] alu_out;
  logic              alu_compres;

  // Completion: writeback, branch redirect, illegal-op report
  logic              done;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;
  logic              illegal;

  modport slave (
    input  in_valid, in_instr, in_src_a, in_src_b, in_pc, flush,
    input  alu_out, alu_compres,
    output in_ready,
    output alu_op, alu_res, alu_register, alu_ltgt, alu_eq,
    output done, wb_en, wb_data, br_taken, br_target, illegal
  );

  modport master (
    output in_valid, in_instr, in_src_a, in_src_b, in_pc, flush,
    output alu_out, alu_compres,
    input  in_ready,
    input  alu_op, alu_res, alu_register, alu_ltgt, alu_eq,
    input  done, wb_en, wb_data, br_taken, br_target, illegal
  );

endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer sitting between decode and the 16-bit ALU.
// It accepts one instruction, presents it to the ALU for one settle cycle, and
// captures the result. It then reports either a writeback or a branch redirect.
// Every output is a flop. Throughput is one instruction per three cycles.
module alu_exec_ctrl #(
  parameter int         DATA_W = 16,
  parameter int         OFF_W  = 8,
  parameter logic [3:0] NOP_OP = 4'h1
) (
  input  logic          clock,
  input  logic          reset,
  alu_exec_ctrl_if.slave bus
);

  localparam logic [3:0] OP_ADDSUB = 4'h0;
  localparam logic [3:0] OP_BRANCH = 4'h4;
  localparam logic [3:0] OP_EPAR   = 4'h5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e            state_q, state_d;

  // Latched instruction fields needed after the accept edge
  logic [3:0]        op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [DATA_W-1:0] pc_q, pc_d;

  // Registered outputs
  logic              in_ready_q, in_ready_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d;
  logic [DATA_W-1:0] alu_register_q, alu_register_d;
  logic [2:0]        alu_ltgt_q, alu_ltgt_d;
  logic              alu_eq_q, alu_eq_d;
  logic              done_q, done_d;
  logic              wb_en_q, wb_en_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              br_taken_q, br_taken_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;
  logic              illegal_q, illegal_d;

  logic [3:0]        in_op;
  logic              in_op_legal;
  logic [DATA_W-1:0] off_sext;

  assign in_op       = bus.in_instr[15:12];
  assign in_op_legal = (in_op == OP_ADDSUB) || (in_op == OP_EPAR) || (in_op == OP_BRANCH);
  assign off_sext    = {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};

  // Next-state and next-output logic for the IDLE -> EXEC -> COMMIT sequence
  always_comb begin
    // NOTE: every signal gets a default before the case; an unassigned path would infer a latch.
    state_d        = state_q;
    op_d           = op_q;
    off_d          = off_q;
    pc_d           = pc_q;
    in_ready_d     = in_ready_q;
    alu_op_d       = alu_op_q;
    alu_res_d      = alu_res_q;
    alu_register_d = alu_register_q;
    alu_ltgt_d     = alu_ltgt_q;
    alu_eq_d       = alu_eq_q;
    wb_data_d      = wb_data_q;
    br_target_d    = br_target_q;
    done_d         = 1'b0;
    wb_en_d        = 1'b0;
    br_taken_d     = 1'b0;
    illegal_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // flush blocks acceptance even with a valid instruction waiting
        if (bus.in_valid && !bus.flush) begin
          op_d  = in_op;
          off_d = bus.in_instr[OFF_W-1:0];
          pc_d  = bus.in_pc;
          if (in_op_legal) begin
            state_d        = EXEC;
            in_ready_d     = 1'b0;
            alu_op_d       = in_op;
            alu_res_d      = bus.in_src_a;
            alu_register_d = bus.in_src_b;
            alu_ltgt_d     = bus.in_instr[10:8];
            alu_eq_d       = bus.in_instr[11];
          end else begin
            illegal_d = 1'b1;
          end
        end
      end

      EXEC: begin
        if (bus.flush) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
          alu_op_d   = NOP_OP;
        end else begin
          // The ALU has settled for a full cycle; capture its result now
          state_d     = COMMIT;
          done_d      = 1'b1;
          br_target_d = pc_q + DATA_W'(1) + off_sext;
          if (op_q == OP_BRANCH) begin
            br_taken_d = bus.alu_compres;
          end else begin
            wb_en_d   = 1'b1;
            wb_data_d = bus.alu_out;
          end
        end
      end

      COMMIT: begin
        // done is already visible this cycle; flush changes nothing here
        state_d    = IDLE;
        in_ready_d = 1'b1;
        alu_op_d   = NOP_OP;
      end

      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        alu_op_d   = NOP_OP;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= NOP_OP;
      off_q          <= '0;
      pc_q           <= '0;
      in_ready_q     <= 1'b1;
      alu_op_q       <= NOP_OP;
      alu_res_q      <= '0;
      alu_register_q <= '0;
      alu_ltgt_q     <= '0;
      alu_eq_q       <= 1'b0;
      done_q         <= 1'b0;
      wb_en_q        <= 1'b0;
      wb_data_q      <= '0;
      br_taken_q     <= 1'b0;
      br_target_q    <= '0;
      illegal_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
      state_q        <= state_d;
      op_q           <= op_d;
      off_q          <= off_d;
      pc_q           <= pc_d;
      in_ready_q     <= in_ready_d;
      alu_op_q       <= alu_op_d;
      alu_res_q      <= alu_res_d;
      alu_register_q <= alu_register_d;
      alu_ltgt_q     <= alu_ltgt_d;
      alu_eq_q       <= alu_eq_d;
      done_q         <= done_d;
      wb_en_q        <= wb_en_d;
      wb_data_q      <= wb_data_d;
      br_taken_q     <= br_taken_d;
      br_target_q    <= br_target_d;
      illegal_q      <= illegal_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_res      = alu_res_q;
  assign bus.alu_register = alu_register_q;
  assign bus.alu_ltgt     = alu_ltgt_q;
  assign bus.alu_eq       = alu_eq_q;
  assign bus.done         = done_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.br_taken     = br_taken_q;
  assign bus.br_target    = br_target_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl. The bench plays both decode stage and
// ALU. Expectations come from the instruction fields and operands directly.
module tb_alu_exec_ctrl;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_exec_ctrl_if #(.DATA_W(16)) bus ();

  alu_exec_ctrl #(.DATA_W(16), .OFF_W(8), .NOP_OP(4'h1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: add/sub, even parity, and a flag-selected compare
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic eq);
    case (op)
      4'h0:    return eq ? a + b : a - b;
      4'h5:    return {15'd0, ^a};
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic logic alu_cmp(input logic [2:0] ltgt, input logic eq,
                                   input logic [15:0] a, input logic [15:0] b);
    logic lt, gt;
    lt = ltgt[2] ? ($signed(a) < $signed(b)) : (a < b);
    gt = ltgt[2] ? ($signed(a) > $signed(b)) : (a > b);
    return (eq && (a == b)) || (ltgt[0] && lt) || (ltgt[1] && gt);
  endfunction

  always_comb begin
    bus.alu_out     = alu_fn(bus.alu_op, bus.alu_res, bus.alu_register, bus.alu_eq);
    bus.alu_compres = alu_cmp(bus.alu_ltgt, bus.alu_eq, bus.alu_res, bus.alu_register);
  end

  // Reference result computed from the instruction with plain integer arithmetic
  function automatic logic [15:0] ref_result(input logic [15:0] instr, input logic [15:0] a,
                                             input logic [15:0] b);
    int sum;
    int ones;
    if (instr[15:12] == 4'h0) begin
      sum = instr[11] ? int'(a) + int'(b) : int'(a) - int'(b);
      return 16'(sum % 65536);
    end
    ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(a[i]);
    return 16'(ones % 2);
  endfunction

  function automatic logic [15:0] ref_target(input logic [15:0] pc, input logic [7:0] off);
    int t;
    t = int'(pc) + 1 + int'($signed(off)) + 65536;
    return 16'(t % 65536);
  endfunction

  // Drive one legal instruction and check EXEC, COMMIT and the return to IDLE
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] pc, input string tag);
    logic [3:0]  op;
    logic        is_br;
    logic [15:0] exp_data;
    logic        exp_tk;
    logic [15:0] exp_tgt;
    op       = instr[15:12];
    is_br    = (op == 4'h4);
    exp_data = ref_result(instr, a, b);
    exp_tk   = is_br ? alu_cmp(instr[10:8], instr[11], a, b) : 1'b0;
    exp_tgt  = ref_target(pc, instr[7:0]);

    bus.in_instr = instr;
    bus.in_src_a = a;
    bus.in_src_b = b;
    bus.in_pc    = pc;
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_instr = 16'($urandom);
    bus.in_src_a = 16'($urandom);
    bus.in_src_b = 16'($urandom);
    bus.in_pc    = 16'($urandom);

    n_cmp++;
    if ({bus.in_ready, bus.done, bus.alu_op, bus.alu_res, bus.alu_register, bus.alu_ltgt, bus.alu_eq}
        !== {1'b0, 1'b0, op, a, b, instr[10:8], instr[11]}) begin
      n_err++;
      $display("FAIL %s exec: rdy/done/op/res/reg/ltgt/eq got %b %b %h %h %h %b %b want 0 0 %h %h %h %b %b",
               tag, bus.in_ready, bus.done, bus.alu_op, bus.alu_res, bus.alu_register, bus.alu_ltgt,
               bus.alu_eq, op, a, b, instr[10:8], instr[11]);
    end

    @(posedge clock); #1;
    n_cmp++;
    if ({bus.done, bus.in_ready, bus.wb_en, bus.br_taken, bus.alu_op} !== {1'b1, 1'b0, !is_br, exp_tk, op}) begin
      n_err++;
      $display("FAIL %s commit: done/rdy/wb_en/br_taken/op got %b %b %b %b %h want 1 0 %b %b %h",
               tag, bus.done, bus.in_ready, bus.wb_en, bus.br_taken, bus.alu_op, !is_br, exp_tk, op);
    end
    if (!is_br) begin
      n_cmp++;
      if (bus.wb_data !== exp_data) begin
        n_err++;
        $display("FAIL %s wb_data: got %h want %h", tag, bus.wb_data, exp_data);
      end
    end
    n_cmp++;
    if (bus.br_target !== exp_tgt) begin
      n_err++;
      $display("FAIL %s br_target: got %h want %h", tag, bus.br_target, exp_tgt);
    end

    @(posedge clock); #1;
    n_cmp++;
    if ({bus.in_ready, bus.done, bus.wb_en, bus.br_taken, bus.illegal, bus.alu_op} !== {5'b10000, 4'h1}) begin
      n_err++;
      $display("FAIL %s idle: rdy/done/wb_en/br_taken/illegal/op got %b %b %b %b %b %h want 1 0 0 0 0 1",
               tag, bus.in_ready, bus.done, bus.wb_en, bus.br_taken, bus.illegal, bus.alu_op);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({bus.in_ready, bus.done, bus.wb_en, bus.br_taken, bus.illegal, bus.wb_data, bus.br_target,
         bus.alu_op, bus.alu_res, bus.alu_register, bus.alu_ltgt, bus.alu_eq}
        !== {5'b10000, 16'h0, 16'h0, 4'h1, 16'h0, 16'h0, 3'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b done=%b wb_en=%b br=%b ill=%b wb=%h tgt=%h op=%h res=%h reg=%h ltgt=%b eq=%b want 1 0 0 0 0 0000 0000 1 0000 0000 000 0",
               bus.in_ready, bus.done, bus.wb_en, bus.br_taken, bus.illegal, bus.wb_data, bus.br_target,
               bus.alu_op, bus.alu_res, bus.alu_register, bus.alu_ltgt, bus.alu_eq);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if ({bus.in_ready, bus.done, bus.alu_op} !== {2'b10, 4'h1}) begin
      n_err++;
      $display("FAIL reset_idle: rdy/done/op got %b %b %h want 1 0 1", bus.in_ready, bus.done, bus.alu_op);
    end
  endtask

  task automatic test_add();
    run_instr(16'h0800, 16'h1234, 16'h0011, 16'h0100, "add");
  endtask

  task automatic test_sub_wrap();
    run_instr(16'h0000, 16'h0001, 16'h0002, 16'h0200, "sub_wrap");
    n_cmp++;
    if (bus.wb_data !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sub_wrap_hold: got %h want FFFF", bus.wb_data);
    end
  endtask

  task automatic test_parity();
    run_instr(16'h5000, 16'h0007, 16'h0000, 16'h0300, "epar_odd");
    n_cmp++;
    if (bus.wb_data !== 16'h0001) begin
      n_err++;
      $display("FAIL epar_odd_value: got %h want 0001", bus.wb_data);
    end
    run_instr(16'h5000, 16'h0003, 16'h0000, 16'h0300, "epar_even");
    n_cmp++;
    if (bus.wb_data !== 16'h0000) begin
      n_err++;
      $display("FAIL epar_even_value: got %h want 0000", bus.wb_data);
    end
  endtask

  task automatic test_branch();
    run_instr(16'h48FC, 16'h0042, 16'h0042, 16'h0010, "br_taken");
    n_cmp++;
    if (bus.br_target !== 16'h000D) begin
      n_err++;
      $display("FAIL br_target_const: got %h want 000D", bus.br_target);
    end
    run_instr(16'h48FC, 16'h0042, 16'h0043, 16'h0010, "br_not_taken");
    run_instr(16'h437F, 16'hFFFF, 16'hFFF0, 16'hFFFF, "br_wrap_target");
  endtask

  task automatic test_illegal();
    bus.in_instr = 16'h7000;
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.illegal, bus.done, bus.in_ready, bus.alu_op} !== {3'b101, 4'h1}) begin
      n_err++;
      $display("FAIL illegal_pulse: ill/done/rdy/op got %b %b %b %h want 1 0 1 1",
               bus.illegal, bus.done, bus.in_ready, bus.alu_op);
    end
    @(posedge clock); #1;
    n_cmp++;
    if ({bus.illegal, bus.done, bus.in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL illegal_after: ill/done/rdy got %b %b %b want 0 0 1", bus.illegal, bus.done, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    bus.in_instr = 16'h0800;
    bus.in_src_a = a;
    bus.in_src_b = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1;
      if (i == 8) bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.in_ready, bus.done} !== {(i % 3) == 2, (i % 3) == 1}) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: rdy/done got %b %b want %b %b", i, bus.in_ready, bus.done,
                 (i % 3) == 2, (i % 3) == 1);
      end
      if ((i % 3) == 1) begin
        n_cmp++;
        if (bus.wb_data !== ref_result(16'h0800, a, b)) begin
          n_err++;
          $display("FAIL b2b_data%0d: got %h want %h", i, bus.wb_data, ref_result(16'h0800, a, b));
        end
      end
    end
  endtask

  task automatic test_flush();
    // Flush during EXEC: no done, back to IDLE
    bus.in_instr = 16'h0800;
    bus.in_src_a = 16'h0101;
    bus.in_src_b = 16'h0202;
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    n_cmp++;
    if ({bus.done, bus.wb_en, bus.br_taken, bus.in_ready, bus.alu_op} !== {4'b0001, 4'h1}) begin
      n_err++;
      $display("FAIL flush_exec: done/wb/br/rdy/op got %b %b %b %b %h want 0 0 0 1 1",
               bus.done, bus.wb_en, bus.br_taken, bus.in_ready, bus.alu_op);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_exec_late: done got %b want 0", bus.done);
    end

    // Flush in IDLE blocks acceptance
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    n_cmp++;
    if ({bus.in_ready, bus.alu_op} !== {1'b1, 4'h1}) begin
      n_err++;
      $display("FAIL flush_idle: rdy/op got %b %h want 1 1", bus.in_ready, bus.alu_op);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_done: got %b want 0", bus.done);
    end

    // Flush during COMMIT: done of that cycle stays visible
    bus.in_instr = 16'h0800;
    bus.in_src_a = 16'h0010;
    bus.in_src_b = 16'h0020;
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    bus.flush = 1'b1;
    n_cmp++;
    if ({bus.done, bus.wb_data} !== {1'b1, 16'h0030}) begin
      n_err++;
      $display("FAIL flush_commit_done: done/wb got %b %h want 1 0030", bus.done, bus.wb_data);
    end
    @(posedge clock); #1;
    bus.flush = 1'b0;
    n_cmp++;
    if ({bus.done, bus.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_commit_after: done/rdy got %b %b want 0 1", bus.done, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    bus.in_instr = 16'h0800;
    bus.in_src_a = 16'h1111;
    bus.in_src_b = 16'h2222;
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.done, bus.wb_en, bus.br_taken, bus.illegal, bus.wb_data, bus.br_target,
         bus.alu_op, bus.alu_res, bus.alu_register, bus.alu_ltgt, bus.alu_eq}
        !== {5'b10000, 16'h0, 16'h0, 4'h1, 16'h0, 16'h0, 3'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: rdy=%b done=%b op=%h res=%h reg=%h wb=%h tgt=%h want 1 0 1 0000 0000 0000 0000",
               bus.in_ready, bus.done, bus.alu_op, bus.alu_res, bus.alu_register, bus.wb_data, bus.br_target);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_no_done: got %b want 0", bus.done);
    end
    run_instr(16'h0800, 16'h0005, 16'h0006, 16'h0040, "after_reset");
  endtask

  task automatic test_random();
    logic [15:0] instr;
    logic [3:0]  op;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(3, 0))
        0:       op = 4'h0;
        1:       op = 4'h5;
        2:       op = 4'h4;
        default: begin
          op = 4'($urandom_range(15, 0));
          while (op == 4'h0 || op == 4'h4 || op == 4'h5) op = 4'($urandom_range(15, 0));
        end
      endcase
      instr = {op, 12'($urandom)};
      if (op == 4'h0 || op == 4'h4 || op == 4'h5) begin
        run_instr(instr, 16'($urandom), 16'($urandom), 16'($urandom), $sformatf("rand%0d", n));
      end else begin
        bus.in_instr = instr;
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({bus.illegal, bus.done, bus.in_ready} !== 3'b101) begin
          n_err++;
          $display("FAIL rand%0d_illegal: ill/done/rdy got %b %b %b want 1 0 1", n,
                   bus.illegal, bus.done, bus.in_ready);
        end
      end
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.in_instr = 16'h0;
    bus.in_src_a = 16'h0;
    bus.in_src_b = 16'h0;
    bus.in_pc    = 16'h0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_parity();
    test_branch();
    test_illegal();
    test_add();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
